eeprom_req_arbiter: RTL and testbench
=====================================

Name: eeprom_req_arbiter

Overview:
Shares the single serial EEPROM read/write engine between two independent requesters.
- Round-robin arbitration between the requesters.
- Issues one WR or RD strobe per transaction to the engine and waits for its ACK, with a timeout.
- Returns read data or completion status to the winning requester.
- After every successful write, enforces the EEPROM internal write-cycle recovery time before the next transaction.
- Sits between client logic (config loader, debug port) and the EEPROM engine.

Parameters:
TIMEOUT, 4096, max clocks in WAIT_ACK before aborting; must be ≥2 and < 2^TO_W
TO_W, 13, width of timeout counter
TWR_CYCLES, 1000, clocks of post-write recovery (EEPROM tWR); must be ≥1
TWR_W, 10, width of recovery counter; TWR_CYCLES must be < 2^TWR_W

Ports:
CLK  in  1  system clock, all logic on posedge
RESET  in  1  synchronous reset, active-high
req  in  2  per-requester request, held until gnt
we  in  2  per-requester 1=write, 0=read
addr0, addr1  in  11 each  requester byte address
wdata0, wdata1  in  8 each  requester write data
gnt  out  2  one-hot, one-cycle pulse, request accepted
done  out  2  one-hot, one-cycle pulse, transaction finished
err  out  1  valid with done; 1 = ACK timeout
rdata  out  8  read data, valid with done on a read
busy  out  1  high in any state except IDLE
eng_wr  out  1  one-cycle write strobe to engine
eng_rd  out  1  one-cycle read strobe to engine
eng_addr  out  11  address to engine, stable from strobe until ack
eng_wdata  out  8  write data to engine, stable from strobe until ack
eng_rdata  in  8  engine read data, valid when eng_ack=1
eng_ack  in  1  engine end-of-transaction acknowledge

Behaviour:
- Reset: all outputs 0; state IDLE; rr_last=1, so requester 0 has first priority; counters 0. Reset mid-transaction drops strobes on the next edge and produces no done pulse.
- States: IDLE, ISSUE, WAIT_ACK, DONE, RECOVER. All outputs are registered.
- IDLE: at an edge with any req bit high:
  - Winner = the requester that is not rr_last if it is requesting, else the other.
  - Latch we/addr/wdata of the winner; go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[winner]=1.
  - eng_wr=we, eng_rd=~we.
  - eng_addr/eng_wdata driven from the latch.
  - rr_last<=winner; clear timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - Strobes low; eng_addr/eng_wdata held; counter increments each cycle.
  - eng_ack=1: capture eng_rdata (reads only, else rdata keeps its old value); err<=0; go to DONE.
  - eng_ack=0 and counter==TIMEOUT-1: err<=1; go to DONE.
  - ACK and timeout in the same cycle: ACK wins.
  - eng_ack during ISSUE is ignored.
- DONE (exactly 1 cycle):
  - done[winner]=1; err/rdata valid.
  - Next state: RECOVER if write and err=0, else IDLE.
  - rdata holds its value until the next read completes.
- RECOVER: count TWR_CYCLES clocks, then go to IDLE; requests wait.
- Latency:
  - Request sampled in IDLE at edge N: gnt and strobe high in cycle N+1.
  - ACK sampled at edge M: done high in cycle M+1.
- Requester rules:
  - req deasserted before gnt = withdrawn, with no side effects.
  - Inputs are sampled only at the IDLE accept edge; later changes are ignored.
  - Requester must drop req in the cycle after gnt, otherwise it is treated as a new request.
- Both requests held continuously: grants strictly alternate 0,1,0,1.
- busy=1 in ISSUE, WAIT_ACK, DONE and RECOVER.
- Invariants:
  - gnt, done, eng_wr and eng_rd are each one-hot or zero.
  - eng_wr and eng_rd are never both high.

Decomposition:
- Shared package holds:
  - state encoding, one-hot 5-bit, constants ST_IDLE..ST_RECOVER;
  - YES/NO constants;
  - EEPROM address width 11 and data width 8.
- One natural sub-module: eeprom_rr_pick, a combinational 2-way round-robin winner select from req and rr_last. Everything else stays in the top.

Test Plan:
- Single write, req0, we=1, addr=0x123, wdata=0xA5; engine acks 20 clocks after the strobe.
  - Required: gnt0 and eng_wr one cycle, eng_addr=0x123, eng_wdata=0xA5.
  - Required: done0 with err=0; busy stays high for TWR_CYCLES more; then IDLE.
- Single read, req1, addr=0x7FF; engine returns eng_rdata=0x3C with ack.
  - Required: eng_rd pulse, done1, rdata=0x3C, err=0, no recovery phase.
- Contention: req0 and req1 both held high from reset, both reads.
  - Required: grant order 0,1,0,1 over 4 transactions; never two gnt in the same cycle.
- Timeout: TIMEOUT=16; read, engine never acks.
  - Required: done high exactly 17 cycles after the strobe, err=1; back to IDLE with no RECOVER.
- ACK coincident with the timeout cycle.
  - Required: err=0, rdata captured.
- Reset asserted during WAIT_ACK.
  - Required: next cycle all outputs 0, no done.
  - Required: a following req0 is granted first.

Source files
------------

// File: rtl/eeprom_req_arbiter_pkg.sv
// Shared definitions for the EEPROM request arbiter.
// Holds the one-hot FSM state encoding, the YES/NO constants, the EEPROM
// address/data widths and a small helper that turns a requester index
// into a one-hot 2-bit vector.
package eeprom_req_arbiter_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_ISSUE    = 5'b00010,
    ST_WAIT_ACK = 5'b00100,
    ST_DONE     = 5'b01000,
    ST_RECOVER  = 5'b10000
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/eeprom_rr_pick.sv
// Combinational 2-way round-robin winner select.
// Ports:
//   req     in  2  request vector
//   rr_last in  1  index of the requester granted most recently
//   vld     out 1  at least one request present
//   win     out 1  winning requester index (meaningful only when vld)
module eeprom_rr_pick
  import eeprom_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       vld,
  output logic       win
);

  // The requester that did not go last has priority; fall back to the other.
  logic pref;
  assign pref = ~rr_last;
  assign vld  = |req;
  assign win  = req[pref] ? pref : ~pref;

endmodule

// File: rtl/eeprom_req_arbiter.sv
// Round-robin arbiter sharing one serial EEPROM read/write engine between
// two requesters. Each transaction issues a single WR/RD strobe, waits for
// the engine ACK (bounded by TIMEOUT), reports done/err/rdata to the winner,
// and after a successful write holds off for TWR_CYCLES clocks of recovery.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   req/we                   per-requester request and write-enable
//   addr0/1, wdata0/1        per-requester address and write data
//   gnt, done                one-hot single-cycle accept / finish pulses
//   err, rdata               completion status and read data, valid with done
//   busy                     high whenever the FSM is not idle
//   eng_wr/eng_rd            single-cycle strobes to the engine
//   eng_addr/eng_wdata       held from strobe until ack
//   eng_rdata/eng_ack        engine response
module eeprom_req_arbiter
  import eeprom_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 13,
  parameter int TWR_CYCLES = 1000,
  parameter int TWR_W      = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              eng_wr,
  output logic              eng_rd,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_wdata,
  input  logic [DATA_W-1:0] eng_rdata,
  input  logic              eng_ack
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              rr_last_q, rr_last_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [TWR_W-1:0]  twr_cnt_q, twr_cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              eng_wr_q, eng_wr_d;
  logic              eng_rd_q, eng_rd_d;
  logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
  logic [DATA_W-1:0] eng_wdata_q, eng_wdata_d;

  logic pick_vld, pick_win;

  eeprom_rr_pick u_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .vld     (pick_vld),
    .win     (pick_win)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    rr_last_d   = rr_last_q;
    to_cnt_d    = to_cnt_q;
    twr_cnt_d   = twr_cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    eng_wr_d    = NO;
    eng_rd_d    = NO;
    err_d       = err_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    eng_addr_d  = eng_addr_q;
    eng_wdata_d = eng_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // Outputs are registered, so gnt/strobe/address are loaded here and
        // appear during the single ISSUE cycle.
        if (pick_vld) begin
          win_d       = pick_win;
          we_d        = we[pick_win];
          eng_addr_d  = pick_win ? addr1 : addr0;
          eng_wdata_d = pick_win ? wdata1 : wdata0;
          gnt_d       = onehot2(pick_win);
          eng_wr_d    = we[pick_win];
          eng_rd_d    = ~we[pick_win];
          busy_d      = YES;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_last_d = win_q;
        to_cnt_d  = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // ACK is checked first so it beats a coincident timeout.
        if (eng_ack) begin
          if (!we_q) rdata_d = eng_rdata;
          err_d   = NO;
          done_d  = onehot2(win_q);
          state_d = ST_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = YES;
          done_d  = onehot2(win_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        twr_cnt_d = '0;
        if (we_q && !err_q) begin
          state_d = ST_RECOVER;
        end else begin
          busy_d  = NO;
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        twr_cnt_d = twr_cnt_q + TWR_W'(1);
        if (twr_cnt_q == TWR_W'(TWR_CYCLES - 1)) begin
          busy_d  = NO;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = NO;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      rr_last_q   <= 1'b1;
      to_cnt_q    <= '0;
      twr_cnt_q   <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      eng_wr_q    <= 1'b0;
      eng_rd_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      rr_last_q   <= rr_last_d;
      to_cnt_q    <= to_cnt_d;
      twr_cnt_q   <= twr_cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      eng_wr_q    <= eng_wr_d;
      eng_rd_q    <= eng_rd_d;
      eng_addr_q  <= eng_addr_d;
      eng_wdata_q <= eng_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign eng_wr    = eng_wr_q;
  assign eng_rd    = eng_rd_q;
  assign eng_addr  = eng_addr_q;
  assign eng_wdata = eng_wdata_q;

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Directed bench for eeprom_req_arbiter with a done/err/rdata scoreboard.
module tb_eeprom_req_arbiter;

  localparam int TIMEOUT    = 24;
  localparam int TO_W       = 5;
  localparam int TWR_CYCLES = 30;
  localparam int TWR_W      = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  req, we;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic        err, busy, eng_wr, eng_rd, eng_ack;
  logic [7:0]  rdata, eng_wdata, eng_rdata;
  logic [10:0] eng_addr;

  eeprom_req_arbiter #(
    .TIMEOUT(TIMEOUT), .TO_W(TO_W), .TWR_CYCLES(TWR_CYCLES), .TWR_W(TWR_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .eng_wr(eng_wr), .eng_rd(eng_rd), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_ack(eng_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] done;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   failed   = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus-level invariants sampled every cycle.
  always @(negedge CLK) begin
    compared++;
    assert ($onehot0(gnt) && $onehot0(done) && !(eng_wr && eng_rd)) else begin
      failed++;
      $error("FAIL invariant: gnt=%b done=%b wr=%b rd=%b expected one-hot-or-zero", gnt, done, eng_wr, eng_rd);
    end
  end

  task automatic push(input logic [1:0] d, input logic e, input logic [7:0] r);
    exp_t x;
    x.done = d; x.err = e; x.rdata = r;
    sb.push_back(x);
  endtask

  task automatic sb_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_done"},  64'(done),  64'(x.done));
      check({tag, "_err"},   64'(err),   64'(x.err));
      check({tag, "_rdata"}, 64'(rdata), 64'(x.rdata));
    end
  endtask

  task automatic wait_gnt(input int bound);
    int i = 0;
    while (gnt == 2'b00 && i < bound) begin
      @(negedge CLK);
      i++;
    end
    if (gnt == 2'b00) check("gnt_seen", 64'(gnt != 2'b00), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (done == 2'b00 && i < bound) begin
      @(negedge CLK);
      i++;
    end
    if (done == 2'b00) check({tag, "_done_seen"}, 64'(done != 2'b00), 64'd1);
    else sb_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; eng_rdata = 8'hEE; eng_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {gnt, done, err, rdata, busy, eng_wr, eng_rd, eng_addr, eng_wdata}, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: single write from requester 0, ack 20 clocks after the strobe
    req = 2'b01; we = 2'b01; addr0 = 11'h123; wdata0 = 8'hA5;
    wait_gnt(5);
    check("wr_gnt", gnt, 2'b01);
    check("wr_strobe", {eng_wr, eng_rd}, 2'b10);
    check("wr_addr", eng_addr, 11'h123);
    check("wr_wdata", eng_wdata, 8'hA5);
    check("wr_busy", busy, 1'b1);
    req = 2'b00; addr0 = 11'h000; wdata0 = 8'h00;
    push(2'b01, 1'b0, last_rd);
    @(negedge CLK);
    check("wr_strobe_drop", {gnt, eng_wr, eng_rd}, 4'b0000);
    check("wr_addr_held", {eng_addr, eng_wdata}, {11'h123, 8'hA5});
    repeat (19) @(negedge CLK);
    eng_ack = 1'b1;
    @(negedge CLK);
    eng_ack = 1'b0;
    check("wr_done_latency", done, 2'b01);
    wait_done("wr", 3);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy) break;
      n++;
    end
    check("wr_recover_len", 64'(n), 64'(TWR_CYCLES));

    // 2: single read from requester 1, no recovery afterwards
    req = 2'b10; we = 2'b00; addr1 = 11'h7FF;
    wait_gnt(5);
    check("rd_gnt", gnt, 2'b10);
    check("rd_strobe", {eng_wr, eng_rd}, 2'b01);
    check("rd_addr", eng_addr, 11'h7FF);
    req = 2'b00;
    push(2'b10, 1'b0, 8'h3C);
    last_rd = 8'h3C;
    repeat (3) @(negedge CLK);
    eng_ack = 1'b1; eng_rdata = 8'h3C;
    @(negedge CLK);
    eng_ack = 1'b0; eng_rdata = 8'hEE;
    wait_done("rd", 3);
    @(negedge CLK);
    check("rd_no_recover", busy, 1'b0);

    // 3: contention, both reads held from reset
    RESET = 1'b1; req = 2'b11; we = 2'b00; addr0 = 11'h010; addr1 = 11'h020;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    last_rd = 8'h00;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(10);
      check("rr_order", gnt, (t % 2) ? 2'b10 : 2'b01);
      push((t % 2) ? 2'b10 : 2'b01, 1'b0, 8'(8'h10 + t));
      last_rd = 8'(8'h10 + t);
      repeat (2) @(negedge CLK);
      eng_ack = 1'b1; eng_rdata = 8'(8'h10 + t);
      @(negedge CLK);
      eng_ack = 1'b0; eng_rdata = 8'hEE;
      wait_done("rr", 3);
      @(negedge CLK);
    end
    req = 2'b00;
    repeat (3) @(negedge CLK);

    // 4: read that never gets an ack
    req = 2'b01; we = 2'b00; addr0 = 11'h055;
    wait_gnt(5);
    check("to_strobe", eng_rd, 1'b1);
    req = 2'b00;
    push(2'b01, 1'b1, last_rd);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      n++;
      if (done != 2'b00) break;
    end
    check("to_latency", 64'(n), 64'(TIMEOUT + 1));
    wait_done("to", 1);
    @(negedge CLK);
    check("to_no_recover", busy, 1'b0);

    // 5: ack arrives in the very cycle the timeout would fire
    req = 2'b10; we = 2'b00; addr1 = 11'h066;
    wait_gnt(5);
    req = 2'b00;
    push(2'b10, 1'b0, 8'h5A);
    last_rd = 8'h5A;
    repeat (TIMEOUT) @(negedge CLK);
    eng_ack = 1'b1; eng_rdata = 8'h5A;
    @(negedge CLK);
    eng_ack = 1'b0; eng_rdata = 8'hEE;
    check("tie_done_latency", done, 2'b10);
    wait_done("tie", 1);
    repeat (2) @(negedge CLK);

    // 6: reset in WAIT_ACK, then both request and requester 0 must win
    req = 2'b01; we = 2'b00; addr0 = 11'h0AA;
    wait_gnt(5);
    req = 2'b00;
    repeat (3) @(negedge CLK);
    RESET = 1'b1; eng_ack = 1'b1; eng_rdata = 8'h77;
    @(negedge CLK);
    eng_ack = 1'b0;
    check("rst_mid_outputs", {gnt, done, err, rdata, busy, eng_wr, eng_rd, eng_addr, eng_wdata}, 64'd0);
    @(negedge CLK);
    check("rst_mid_no_done", done, 2'b00);
    RESET = 1'b0; req = 2'b11; we = 2'b00; addr0 = 11'h011; addr1 = 11'h022;
    wait_gnt(5);
    check("rst_first_gnt", gnt, 2'b01);
    check("rst_first_addr", eng_addr, 11'h011);
    req = 2'b00;
    push(2'b01, 1'b0, 8'h99);
    @(negedge CLK);
    eng_ack = 1'b1; eng_rdata = 8'h99;
    @(negedge CLK);
    eng_ack = 1'b0; eng_rdata = 8'hEE;
    wait_done("rst", 3);
    repeat (3) @(negedge CLK);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
